// File: rtl/uart_rx_fifo.sv
// =============================================================================
// Module  : uart_rx_fifo
// Brief   : First-word fall-through receive FIFO for UART frames, storing data
//           with frame/parity error flags, plus level, threshold and overrun.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_valid_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      wr_frame_err_i,
    input  logic                      wr_parity_err_i,
    input  logic                      rd_en_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      rd_frame_err_o,
    output logic                      rd_parity_err_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    level_o,
    input  logic [$clog2(DEPTH):0]    thresh_i,
    output logic                      thresh_o,
    output logic                      overrun_o,
    input  logic                      overrun_clr_i,
    input  logic                      flush_i
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_PW = c_AW + 1;
    localparam int unsigned c_EW = DATA_WIDTH + 2;

    logic [c_EW-1:0] mem_q [DEPTH];

    logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic            overrun_q, overrun_d;

    logic            w_empty;
    logic            w_full;
    logic            w_do_wr;
    logic            w_do_rd;
    logic            w_drop;
    logic [c_PW-1:0] w_level;
    logic [c_EW-1:0] w_head;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign w_level = wr_ptr_q - rd_ptr_q;

    // A pop while full frees the slot the same-cycle write lands in.
    assign w_do_wr = wr_valid_i && (!w_full || rd_en_i) && !flush_i;
    assign w_do_rd = rd_en_i && !w_empty && !flush_i;
    assign w_drop  = wr_valid_i && w_full && !rd_en_i && !flush_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Set dominates a same-cycle clear so no drop goes unreported.
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= {wr_parity_err_i, wr_frame_err_i, wr_data_i};
        end
    end

    assign w_head = mem_q[rd_ptr_q[c_AW-1:0]];

    assign rd_data_o       = w_empty ? '0   : w_head[DATA_WIDTH-1:0];
    assign rd_frame_err_o  = w_empty ? 1'b0 : w_head[DATA_WIDTH];
    assign rd_parity_err_o = w_empty ? 1'b0 : w_head[DATA_WIDTH+1];

    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign level_o   = w_level;
    assign thresh_o  = (thresh_i != '0) && (w_level >= thresh_i);
    assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive FIFO that buffers completed frames from `rx_shiftreg` until the Wishbone register interface reads them. It stores each received byte with its frame-error and parity-error flags, and shows the head entry combinationally (first-word fall-through). It reports fill level, full/empty status, a programmable-threshold indication and a sticky overrun flag.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, at least 2
- DATA_WIDTH, 8, width of one data entry

Ports:
- clk_i  input  1  system clock; all state changes on its rising edge
- rst_i  input  1  reset; asynchronous, active-high
- wr_valid_i  input  1  single-cycle strobe from `rx_shiftreg`: a frame is complete
- wr_data_i  input  DATA_WIDTH  received data bits; LSB is the first bit received
- wr_frame_err_i  input  1  stop bit was sampled low for this frame
- wr_parity_err_i  input  1  parity mismatch for this frame
- rd_en_i  input  1  pop strobe from the register interface (read of the RX data register)
- rd_data_o  output  DATA_WIDTH  head entry data; 0 when empty
- rd_frame_err_o  output  1  head entry frame-error flag; 0 when empty
- rd_parity_err_o  output  1  head entry parity-error flag; 0 when empty
- empty_o  output  1  level == 0
- full_o  output  1  level == DEPTH
- level_o  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- thresh_i  input  $clog2(DEPTH)+1  threshold; 0 disables the threshold indication
- thresh_o  output  1  thresh_i != 0 and level_o >= thresh_i
- overrun_o  output  1  sticky flag: a frame was dropped because the FIFO was full
- overrun_clr_i  input  1  clears overrun_o
- flush_i  input  1  synchronous flush of all entries

## Operation
- Storage: DEPTH x (DATA_WIDTH+2) register array holding {parity_err, frame_err, data}. Array contents are not reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits, wrapping modulo 2·DEPTH.
  - level = wr_ptr − rd_ptr, modulo 2·DEPTH.
  - full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
- Write: when wr_valid_i=1 and (not full, or rd_en_i=1 in the same cycle), store the entry at wr_ptr and increment wr_ptr.
- Read: when rd_en_i=1 and not empty, increment rd_ptr. rd_en_i while empty is ignored: no underflow, no state change.
- Simultaneous write and read:
  - When full: the pop frees a slot, the write is accepted, level stays DEPTH and no overrun is flagged.
  - When empty: the write is accepted, the read is ignored, level becomes 1.
  - Otherwise: both occur and level is unchanged.
- Overrun:
  - Set: wr_valid_i=1, full, rd_en_i=0. The frame is dropped, stored entries are untouched, overrun_o is set.
  - Clear: overrun_clr_i=1.
  - If set and clear occur in the same cycle, set wins.
- Flush:
  - flush_i=1 sets both pointers to 0 at the next edge.
  - Flush takes priority over any same-cycle write or read. A write in the flush cycle is discarded and does not set overrun.
  - overrun_o is not affected by flush.
- Head outputs: rd_* = mem[rd_ptr[$clog2(DEPTH)-1:0]], gated to 0 when empty.
- Status outputs are combinational from the pointer registers: empty_o, full_o, level_o, thresh_o.
- Reset values: pointers 0, overrun_o 0. Therefore empty_o=1, full_o=0, level_o=0, thresh_o=0, and rd_data_o=rd_frame_err_o=rd_parity_err_o=0.
- Reset mid-operation: all stored entries are discarded immediately (asynchronous). The outputs take their reset values without waiting for a clock edge.

## Timing
- Write at edge N: empty_o, level_o and rd_data_o reflect the new entry from just after edge N. Write-to-read latency is 1 cycle.
- Pop at edge N: rd_data_o presents the next entry just after edge N. Back-to-back pops on consecutive cycles are supported, one entry per cycle.
- overrun_o rises just after the edge at which the drop occurs and falls just after the edge with overrun_clr_i=1.
- Inputs are sampled on clk_i only. rd_en_i and wr_valid_i are treated as per-cycle strobes: holding either high for k cycles causes k operations.
- There are no combinational paths from wr_* or rd_en_i to any output.

## Test plan
- Reset, then write 0xA5 with frame_err=1 → just after the write edge: empty_o=0, level_o=1, rd_data_o=0xA5, rd_frame_err_o=1. Pop → empty_o=1, rd_data_o=0.
- Write 16 bytes 0x00..0x0F (DEPTH=16) → full_o=1, level_o=16. A 17th write 0xFF → overrun_o=1, level stays 16. Pop 16 times → data 0x00..0x0F in order with no 0xFF. overrun_clr_i → overrun_o=0.
- While full, assert wr_valid_i with 0x55 and rd_en_i together → level stays 16, overrun_o=0, and 0x55 is read out last.
- While empty, assert wr_valid_i with 0x33 and rd_en_i together → level_o=1, rd_data_o=0x33. rd_en_i alone on an empty FIFO → no change.
- thresh_i=4: write 3 entries → thresh_o=0; a 4th write → thresh_o=1; one pop → thresh_o=0. thresh_i=0 → thresh_o=0 at any level.
- Fill 5 entries, then assert flush_i with a same-cycle write → level_o=0, empty_o=1, overrun_o unchanged. Assert rst_i asynchronously mid-fill → outputs reach their reset values before the next edge.
